// File: rtl/mblk_scan_gen_pkg.sv
// Shared types for the macroblock scan-order generator.
// Block-size encoding, FSM state type and the block-size helper.
package mblk_scan_gen_pkg;

    typedef enum logic [1:0] {
        MBLK8X8   = 2'b00,
        MBLK16X16 = 2'b01,
        MBLK32X32 = 2'b10,
        MBLK64X64 = 2'b11
    } teMacroBlockType;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } teScanState;

    localparam int BLK_IDX_W = 24;

    // log2 of the block edge: 3 (8 px) .. 6 (64 px)
    function automatic logic [2:0] mblk_log2size(input teMacroBlockType m);
        return 3'd3 + {1'b0, m};
    endfunction

endpackage

// File: rtl/mblk_axis_cnt.sv
// One scan axis: block origin, pixel position, clipped block limit.
// Ports: iClr/iAdv/iRew/iInc step controls; iLog2 block size; iDim
// frame extent; oPos/oOrg position and origin; oAtLim last pixel of
// the (clipped) block on this axis; oLastBlk block touches the edge.
module mblk_axis_cnt
    import mblk_scan_gen_pkg::*;
#(
    parameter int W = 12
) (
    input  logic         iClk,
    input  logic         iRst,
    input  logic         iClr,
    input  logic         iAdv,
    input  logic         iRew,
    input  logic         iInc,
    input  logic [2:0]   iLog2,
    input  logic [W-1:0] iDim,
    output logic [W-1:0] oPos,
    output logic [W-1:0] oOrg,
    output logic         oAtLim,
    output logic         oLastBlk
);

    logic [W-1:0] org_q, org_d;
    logic [W-1:0] pos_q, pos_d;
    logic [W:0]   size;
    logic [W:0]   blk_end;

    // One extra bit so origin+size cannot wrap near the max extent
    always_comb begin
        size    = (W+1)'(1) << iLog2;
        blk_end = {1'b0, org_q} + size;
    end

    assign oLastBlk = blk_end >= {1'b0, iDim};
    assign oAtLim   = oLastBlk ? (pos_q == iDim - W'(1))
                               : ({1'b0, pos_q} == blk_end - (W+1)'(1));
    assign oPos     = pos_q;
    assign oOrg     = org_q;

    always_comb begin
        org_d = org_q;
        pos_d = pos_q;
        if (iClr) begin
            org_d = '0;
            pos_d = '0;
        end else if (iAdv) begin
            // only issued when not the last block, so blk_end fits W bits
            org_d = blk_end[W-1:0];
            pos_d = blk_end[W-1:0];
        end else if (iRew) begin
            pos_d = org_q;
        end else if (iInc) begin
            pos_d = pos_q + W'(1);
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            org_q <= '0;
            pos_q <= '0;
        end else begin
            org_q <= org_d;
            pos_q <= pos_d;
        end
    end

endmodule

// File: rtl/mblk_scan_gen.sv
// Macroblock scan-order coordinate/address generator.
// Ports: iStart/ieMode/iWidth/iHeight/iBase/iStride configure a scan;
// oValid/iReady beat handshake carrying oX/oY/oAddr/oBlkIdx and block
// flags; oBusy in RUN; oDone/oErr end-of-scan pulses; iAbort stops.
module mblk_scan_gen
    import mblk_scan_gen_pkg::*;
#(
    parameter int X_W    = 12,
    parameter int Y_W    = 12,
    parameter int ADDR_W = 32
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iStart,
    input  logic [1:0]           ieMode,
    input  logic [X_W-1:0]       iWidth,
    input  logic [Y_W-1:0]       iHeight,
    input  logic [ADDR_W-1:0]    iBase,
    input  logic [ADDR_W-1:0]    iStride,
    input  logic                 iAbort,
    output logic                 oBusy,
    output logic                 oDone,
    output logic                 oErr,
    output logic                 oValid,
    input  logic                 iReady,
    output logic [X_W-1:0]       oX,
    output logic [Y_W-1:0]       oY,
    output logic [ADDR_W-1:0]    oAddr,
    output logic [BLK_IDX_W-1:0] oBlkIdx,
    output logic                 oBlkFirst,
    output logic                 oBlkLast,
    output logic                 oFrameLast
);

    teScanState      state_q, state_d;
    teMacroBlockType mode_q, mode_d;
    logic [X_W-1:0]  w_q, w_d;
    logic [Y_W-1:0]  h_q, h_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    // frow: address of (0, y); band: address of (0, block-row origin)
    logic [ADDR_W-1:0] frow_q, frow_d;
    logic [ADDR_W-1:0] band_q, band_d;
    logic [BLK_IDX_W-1:0] blk_q, blk_d;
    logic err_q, err_d;

    logic xClr, xAdv, xRew, xInc;
    logic yClr, yAdv, yRew, yInc;
    logic [X_W-1:0] xPos, xOrg;
    logic [Y_W-1:0] yPos, yOrg;
    logic xAtLim, xLast, yAtLim, yLast;
    logic [2:0] log2sz;
    logic run, fire, frame_last;
    logic [ADDR_W-1:0] frow_nx, bx_a, sz_a;

    assign log2sz     = mblk_log2size(mode_q);
    assign run        = state_q == RUN;
    assign fire       = run && iReady;
    assign frame_last = xAtLim && yAtLim && xLast && yLast;
    assign frow_nx    = frow_q + stride_q;
    assign bx_a       = ADDR_W'(xOrg);
    assign sz_a       = ADDR_W'(1) << log2sz;

    mblk_axis_cnt #(.W(X_W)) u_x (
        .iClk(iClk), .iRst(iRst),
        .iClr(xClr), .iAdv(xAdv), .iRew(xRew), .iInc(xInc),
        .iLog2(log2sz), .iDim(w_q),
        .oPos(xPos), .oOrg(xOrg), .oAtLim(xAtLim), .oLastBlk(xLast)
    );

    mblk_axis_cnt #(.W(Y_W)) u_y (
        .iClk(iClk), .iRst(iRst),
        .iClr(yClr), .iAdv(yAdv), .iRew(yRew), .iInc(yInc),
        .iLog2(log2sz), .iDim(h_q),
        .oPos(yPos), .oOrg(yOrg), .oAtLim(yAtLim), .oLastBlk(yLast)
    );

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        w_d      = w_q;
        h_d      = h_q;
        stride_d = stride_q;
        addr_d   = addr_q;
        frow_d   = frow_q;
        band_d   = band_q;
        blk_d    = blk_q;
        err_d    = 1'b0;
        xClr = 1'b0; xAdv = 1'b0; xRew = 1'b0; xInc = 1'b0;
        yClr = 1'b0; yAdv = 1'b0; yRew = 1'b0; yInc = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (iStart) begin
                    if (iWidth == '0 || iHeight == '0) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d  = RUN;
                        mode_d   = teMacroBlockType'(ieMode);
                        w_d      = iWidth;
                        h_d      = iHeight;
                        stride_d = iStride;
                        addr_d   = iBase;
                        frow_d   = iBase;
                        band_d   = iBase;
                        blk_d    = '0;
                        xClr     = 1'b1;
                        yClr     = 1'b1;
                    end
                end
            end
            RUN: begin
                // final handshake wins over a simultaneous abort
                if (fire && frame_last) begin
                    state_d = DONE;
                end else if (iAbort) begin
                    state_d = DONE;
                end else if (fire) begin
                    if (!xAtLim) begin
                        xInc   = 1'b1;
                        addr_d = addr_q + ADDR_W'(1);
                    end else if (!yAtLim) begin
                        xRew   = 1'b1;
                        yInc   = 1'b1;
                        frow_d = frow_nx;
                        addr_d = frow_nx + bx_a;
                    end else if (!xLast) begin
                        // next block in the same block row
                        xAdv   = 1'b1;
                        yRew   = 1'b1;
                        frow_d = band_q;
                        addr_d = band_q + bx_a + sz_a;
                        blk_d  = blk_q + BLK_IDX_W'(1);
                    end else begin
                        // first block of the next block row
                        xClr   = 1'b1;
                        yAdv   = 1'b1;
                        band_d = frow_nx;
                        frow_d = frow_nx;
                        addr_d = frow_nx;
                        blk_d  = blk_q + BLK_IDX_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q  <= IDLE;
            mode_q   <= MBLK8X8;
            w_q      <= '0;
            h_q      <= '0;
            stride_q <= '0;
            addr_q   <= '0;
            frow_q   <= '0;
            band_q   <= '0;
            blk_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            w_q      <= w_d;
            h_q      <= h_d;
            stride_q <= stride_d;
            addr_q   <= addr_d;
            frow_q   <= frow_d;
            band_q   <= band_d;
            blk_q    <= blk_d;
            err_q    <= err_d;
        end
    end

    assign oBusy      = run;
    assign oValid     = run;
    assign oDone      = state_q == DONE;
    assign oErr       = err_q;
    assign oX         = xPos;
    assign oY         = yPos;
    assign oAddr      = addr_q;
    assign oBlkIdx    = blk_q;
    assign oBlkFirst  = run && xPos == xOrg && yPos == yOrg;
    assign oBlkLast   = run && xAtLim && yAtLim;
    assign oFrameLast = run && frame_last;

endmodule
